gpi_ctrl: RTL and testbench



---
 rtl/gpi_pkg.sv | 26 ++
 rtl/gpi_debounce.sv | 53 +++++
 rtl/gpi_ctrl.sv | 86 ++++++++
 tb/tb_gpi_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpi_pkg.sv
// Shared definitions for the general-purpose input controller.
package gpi_pkg;

  // Register indices on the peripheral bus
  localparam logic [1:0] GPI_ADDR_DATA       = 2'd0;
  localparam logic [1:0] GPI_ADDR_IRQ_EN     = 2'd1;
  localparam logic [1:0] GPI_ADDR_EDGE_SEL   = 2'd2;
  localparam logic [1:0] GPI_ADDR_IRQ_STATUS = 2'd3;

  // Edge-mode encodings held in EDGE_SEL
  localparam logic GPI_EDGE_FALL = 1'b0;
  localparam logic GPI_EDGE_RISE = 1'b1;

  // Pick the rise or fall pulse according to the bit's edge mode
  function automatic logic gpi_edge_event(logic mode, logic rise, logic fall);
    logic ev;
    ev = 1'b0;
    case (mode)
      GPI_EDGE_RISE: ev = rise;
      GPI_EDGE_FALL: ev = fall;
      default:       ev = 1'b0;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/gpi_debounce.sv
// Single-bit synchroniser followed by a stability-count debouncer.
module gpi_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic deb_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   deb_q, deb_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift the pin through the chain; count consecutive cycles s differs from deb
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    if (s == deb_q) begin
      // Any return to the accepted level restarts the count
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      deb_d = s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/gpi_ctrl.sv
// General-purpose input controller: debounced pins, edge interrupts, bus registers.
module gpi_ctrl
  import gpi_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpi_in,
  input  logic             sel,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             irq
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_q;
  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic [WIDTH-1:0] edge_sel_q, edge_sel_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] clr;
  logic             wr_en;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    gpi_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .pin_i (gpi_in[g]),
      .deb_o (deb[g])
    );
  end

  assign wr_en = sel & we;

  // Per-bit edge events and register next-state; a new event beats a same-cycle clear
  always_comb begin
    evt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      evt[i] = gpi_edge_event(edge_sel_q[i], deb[i] & ~deb_q[i], ~deb[i] & deb_q[i]);
    end
    clr        = (wr_en && addr == GPI_ADDR_IRQ_STATUS) ? wr_data : '0;
    irq_en_d   = (wr_en && addr == GPI_ADDR_IRQ_EN) ? wr_data : irq_en_q;
    edge_sel_d = (wr_en && addr == GPI_ADDR_EDGE_SEL) ? wr_data : edge_sel_q;
    status_d   = (status_q & ~clr) | evt;
  end

  // Register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q      <= '0;
      irq_en_q   <= '0;
      edge_sel_q <= '0;
      status_q   <= '0;
    end else begin
      deb_q      <= deb;
      irq_en_q   <= irq_en_d;
      edge_sel_q <= edge_sel_d;
      status_q   <= status_d;
    end
  end

  // Combinational read port, idle-zero when not reading
  always_comb begin
    rd_data = '0;
    if (sel && !we) begin
      case (addr)
        GPI_ADDR_DATA:       rd_data = deb;
        GPI_ADDR_IRQ_EN:     rd_data = irq_en_q;
        GPI_ADDR_EDGE_SEL:   rd_data = edge_sel_q;
        GPI_ADDR_IRQ_STATUS: rd_data = status_q;
        default:             rd_data = '0;
      endcase
    end
  end

  assign irq = |(status_q & irq_en_q);

endmodule

// File: tb/tb_gpi_ctrl.sv
// Directed self-checking bench for gpi_ctrl with default parameters.
module tb_gpi_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] gpi_in;
  logic       sel;
  logic       we;
  logic [1:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       irq;

  int checks;
  int failures;

  gpi_ctrl #(
    .WIDTH           (8),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .gpi_in  (gpi_in),
    .sel     (sel),
    .we      (we),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    logic       exp_irq;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Combinational read at the current point in the low phase
  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string name);
    sel  = 1'b1;
    we   = 1'b0;
    addr = a;
    #1;
    chk(name, {24'd0, rd_data}, {24'd0, exp});
    sel  = 1'b0;
  endtask

  // Write spanning exactly one rising edge, ends at the following negedge
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    sel     = 1'b1;
    we      = 1'b1;
    addr    = a;
    wr_data = d;
    @(negedge clk);
    sel     = 1'b0;
    we      = 1'b0;
    wr_data = 8'h00;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    gpi_in   = 8'hFF;
    sel      = 1'b0;
    we       = 1'b0;
    addr     = 2'd0;
    wr_data  = 8'h00;

    // Reset state, pins held high through reset
    step(3);
    rst_n = 1'b1;
    rd(2'd0, 8'h00, "rst_data");
    rd(2'd1, 8'h00, "rst_irq_en");
    rd(2'd2, 8'h00, "rst_edge_sel");
    rd(2'd3, 8'h00, "rst_status");
    chk("rst_irq", {31'd0, irq}, 32'd0);
    step(5);
    rd(2'd0, 8'h00, "data_edge5");
    step(1);
    rd(2'd0, 8'hFF, "data_edge6");

    // Register access table with pins stable at 0xFF
    vecs[0]  = '{1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 2'd2, 8'h5A, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'd2, 8'h00, 8'h5A, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 2'd1, 8'h3C, 8'h00, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2'd1, 8'h00, 8'h3C, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 2'd2, 8'h00, 8'h5A, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 2'd0, 8'hAA, 8'h00, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 2'd0, 8'h00, 8'hFF, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 2'd3, 8'h00, 8'h00, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 2'd1, 8'h00, 8'h00, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 2'd2, 8'h00, 8'h00, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 2'd1, 8'h00, 8'h00, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 2'd2, 8'h00, 8'h00, 1'b0};
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      sel     = vecs[i].sel;
      we      = vecs[i].we;
      addr    = vecs[i].addr;
      wr_data = vecs[i].wdata;
      #1;
      if (!vecs[i].we) begin
        chk($sformatf("vec%0d_rd", i), {24'd0, rd_data}, {24'd0, vecs[i].exp_rd});
        chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
      end
    end
    @(negedge clk);
    sel = 1'b0;
    we  = 1'b0;

    // All pins fall in falling mode: status without irq, then clear
    gpi_in = 8'h00;
    step(10);
    rd(2'd3, 8'hFF, "fall_all_status");
    chk("fall_all_irq", {31'd0, irq}, 32'd0);
    wr(2'd3, 8'hFF);
    rd(2'd3, 8'h00, "fall_all_cleared");

    // Short 3-cycle pulse on bit 0 is rejected
    gpi_in = 8'h01;
    step(3);
    gpi_in = 8'h00;
    step(10);
    rd(2'd0, 8'h00, "glitch_data");
    rd(2'd3, 8'h00, "glitch_status");

    // Rising edge on bit 0 with interrupt enabled
    wr(2'd2, 8'h01);
    wr(2'd1, 8'h01);
    gpi_in = 8'h01;
    step(5);
    rd(2'd0, 8'h00, "rise0_data_e5");
    step(1);
    rd(2'd0, 8'h01, "rise0_data_e6");
    rd(2'd3, 8'h00, "rise0_status_e6");
    step(1);
    rd(2'd3, 8'h01, "rise0_status_e7");
    chk("rise0_irq_e7", {31'd0, irq}, 32'd1);
    wr(2'd3, 8'h01);
    rd(2'd3, 8'h00, "rise0_cleared");
    chk("rise0_irq_cleared", {31'd0, irq}, 32'd0);

    // Falling edge on bit 3, interrupt disabled, then enabled late
    wr(2'd2, 8'h00);
    wr(2'd1, 8'h00);
    gpi_in = 8'h09;
    step(10);
    rd(2'd3, 8'h00, "bit3_rise_ignored");
    gpi_in = 8'h01;
    step(10);
    rd(2'd3, 8'h08, "bit3_fall_status");
    chk("bit3_irq_masked", {31'd0, irq}, 32'd0);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = 2'd1; wr_data = 8'h08;
    #1;
    chk("bit3_irq_before_en", {31'd0, irq}, 32'd0);
    @(negedge clk);
    sel = 1'b0; we = 1'b0; wr_data = 8'h00;
    chk("bit3_irq_after_en", {31'd0, irq}, 32'd1);
    wr(2'd3, 8'h08);
    chk("bit3_irq_cleared", {31'd0, irq}, 32'd0);
    wr(2'd1, 8'h00);

    // W1C on bit 2 in the same cycle its rise event lands: set wins
    wr(2'd2, 8'h04);
    gpi_in = 8'h05;
    step(6);
    rd(2'd0, 8'h05, "race_data_e6");
    rd(2'd3, 8'h00, "race_status_e6");
    sel = 1'b1; we = 1'b1; addr = 2'd3; wr_data = 8'h04;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; wr_data = 8'h00;
    rd(2'd3, 8'h04, "race_set_wins");

    // DATA is read-only
    wr(2'd0, 8'hAA);
    rd(2'd0, 8'h05, "data_ro");
    wr(2'd1, 8'h04);
    chk("pre_reset_irq", {31'd0, irq}, 32'd1);

    // Reset mid-debounce with counters at 2
    gpi_in = 8'h00;
    step(4);
    rst_n = 1'b0;
    #1;
    chk("midrst_irq", {31'd0, irq}, 32'd0);
    rd(2'd0, 8'h00, "midrst_data");
    rd(2'd3, 8'h00, "midrst_status");
    rd(2'd1, 8'h00, "midrst_irq_en");
    step(2);
    rst_n = 1'b1;
    step(12);
    rd(2'd0, 8'h00, "post_rst_data");
    rd(2'd3, 8'h00, "post_rst_status");
    chk("post_rst_irq", {31'd0, irq}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
